// File: rtl/serial_subtractor_pkg.sv
// Shared constants and FSM encoding for the bit-serial subtractor.
package serial_subtractor_pkg;

   localparam int unsigned DEFAULT_WIDTH = 8;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } state_e;

endpackage : serial_subtractor_pkg

// File: rtl/serial_subtractor_full_subtractor.sv
// Purely combinational one-bit subtractors used by the serial datapath.
module half_subtractor (
   input  logic a,
   input  logic b,
   output logic d,
   output logic bout
);
   assign d    = a ^ b;
   assign bout = ~a & b;
endmodule : half_subtractor

module full_subtractor (
   input  logic a,
   input  logic b,
   input  logic bin,
   output logic d,
   output logic bout
);
   logic d1;
   logic b1;
   logic b2;

   half_subtractor u_hs0 (.a(a),  .b(b),   .d(d1), .bout(b1));
   half_subtractor u_hs1 (.a(d1), .b(bin), .d(d),  .bout(b2));

   // Second stage only borrows when a==b, which gives ~(a^b)&bin.
   assign bout = b1 | b2;
endmodule : full_subtractor

// File: rtl/serial_subtractor.sv
// Bit-serial unsigned subtractor: LSB first, one bit per clock, fixed latency.
module serial_subtractor
   import serial_subtractor_pkg::*;
#(
   parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] diff,
   output logic             bout
);

   localparam int unsigned CNT_W = $clog2(WIDTH) + 1;

   state_e             state_q, state_d;
   logic [WIDTH-1:0]   a_sh_q, a_sh_d;
   logic [WIDTH-1:0]   b_sh_q, b_sh_d;
   logic [WIDTH-1:0]   work_q, work_d;
   logic [WIDTH-1:0]   diff_q, diff_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic               brw_q, brw_d;
   logic               bout_q, bout_d;
   logic               busy_q, busy_d;
   logic               done_q, done_d;

   logic               fs_d_c;
   logic               fs_bout_c;
   logic               accept_c;

   full_subtractor u_fs (
      .a    (a_sh_q[0]),
      .b    (b_sh_q[0]),
      .bin  (brw_q),
      .d    (fs_d_c),
      .bout (fs_bout_c)
   );

   assign accept_c = start && (state_q != ST_RUN);

   // Next-state and datapath update.
   always_comb begin
      state_d = state_q;
      a_sh_d  = a_sh_q;
      b_sh_d  = b_sh_q;
      work_d  = work_q;
      diff_d  = diff_q;
      cnt_d   = cnt_q;
      brw_d   = brw_q;
      bout_d  = bout_q;

      unique case (state_q)
         ST_IDLE: ;
         ST_RUN: begin
            a_sh_d = a_sh_q >> 1;
            b_sh_d = b_sh_q >> 1;
            work_d = {fs_d_c, work_q[WIDTH-1:1]};
            brw_d  = fs_bout_c;
            cnt_d  = cnt_q + CNT_W'(1);
            if (cnt_q == CNT_W'(WIDTH - 1)) begin
               state_d = ST_DONE;
               diff_d  = {fs_d_c, work_q[WIDTH-1:1]};
               bout_d  = fs_bout_c;
            end
         end
         ST_DONE: state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase

      // Results stay put; only the working operands are reloaded.
      if (accept_c) begin
         state_d = ST_RUN;
         a_sh_d  = a;
         b_sh_d  = b;
         brw_d   = 1'b0;
         cnt_d   = '0;
      end

      busy_d = (state_d == ST_RUN);
      done_d = (state_d == ST_DONE);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
         a_sh_q  <= '0;
         b_sh_q  <= '0;
         work_q  <= '0;
         diff_q  <= '0;
         cnt_q   <= '0;
         brw_q   <= 1'b0;
         bout_q  <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         a_sh_q  <= a_sh_d;
         b_sh_q  <= b_sh_d;
         work_q  <= work_d;
         diff_q  <= diff_d;
         cnt_q   <= cnt_d;
         brw_q   <= brw_d;
         bout_q  <= bout_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
      end
   end

   assign busy = busy_q;
   assign done = done_q;
   assign diff = diff_q;
   assign bout = bout_q;

endmodule : serial_subtractor

// File: tb/tb_serial_subtractor.sv
// Directed and randomized checks of serial_subtractor at WIDTH=8.
module tb_serial_subtractor;

   localparam int unsigned W = 8;

   logic         clk;
   logic         rst_n;
   logic         start;
   logic [W-1:0] a;
   logic [W-1:0] b;
   logic         busy;
   logic         done;
   logic [W-1:0] diff;
   logic         bout;

   int pass_cnt  = 0;
   int total_cnt = 0;

   serial_subtractor #(.WIDTH(W)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .start (start),
      .a     (a),
      .b     (b),
      .busy  (busy),
      .done  (done),
      .diff  (diff),
      .bout  (bout)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      total_cnt++;
      assert (obs === expv) pass_cnt++;
      else $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
   endtask

   // Pulse start with the operands, wait for done; leaves time at the done cycle.
   task automatic do_op(input string tag, input logic [W-1:0] ra, input logic [W-1:0] rb,
                        input logic [W-1:0] ed, input logic eb);
      int lat;
      int busy_n;
      a = ra;
      b = rb;
      start = 1'b1;
      tick();
      start = 1'b0;
      lat = 0;
      busy_n = 0;
      while (!done && lat < 20) begin
         if (busy) busy_n++;
         tick();
         lat++;
      end
      chk({tag, ".lat"},  32'(lat),    32'(W));
      chk({tag, ".busy"}, 32'(busy_n), 32'(W));
      chk({tag, ".diff"}, 32'(diff),   32'(ed));
      chk({tag, ".bout"}, 32'(bout),   32'(eb));
   endtask

   initial begin
      int lat;
      int pulses;
      logic [W-1:0] ra;
      logic [W-1:0] rb;
      logic [W:0]   ref9;

      rst_n = 1'b0;
      start = 1'b0;
      a = '0;
      b = '0;
      repeat (3) tick();
      chk("rst.busy", 32'(busy), 32'd0);
      chk("rst.done", 32'(done), 32'd0);
      chk("rst.diff", 32'(diff), 32'd0);
      chk("rst.bout", 32'(bout), 32'd0);
      rst_n = 1'b1;

      // Start on the very first edge after reset release.
      do_op("op5a23", 8'h5A, 8'h23, 8'h37, 1'b0);
      chk("op5a23.busy_at_done", 32'(busy), 32'd0);
      tick();
      chk("op5a23.done_one_cycle", 32'(done), 32'd0);
      chk("op5a23.diff_hold", 32'(diff), 32'h37);
      chk("op5a23.idle_busy", 32'(busy), 32'd0);

      do_op("op1020", 8'h10, 8'h20, 8'hF0, 1'b1);
      tick();
      do_op("op0001", 8'h00, 8'h01, 8'hFF, 1'b1);
      tick();

      // Mid-run start with different operands must be ignored.
      a = 8'h3C;
      b = 8'h0F;
      start = 1'b1;
      tick();
      start = 1'b0;
      repeat (3) tick();
      a = 8'hFF;
      b = 8'hFF;
      start = 1'b1;
      tick();
      start = 1'b0;
      lat = 4;
      while (!done && lat < 20) begin
         tick();
         lat++;
      end
      chk("ign.lat",  32'(lat),  32'd8);
      chk("ign.diff", 32'(diff), 32'h2D);
      chk("ign.bout", 32'(bout), 32'd0);
      pulses = 0;
      repeat (12) begin
         tick();
         if (done) pulses++;
      end
      chk("ign.extra_done", 32'(pulses), 32'd0);
      chk("ign.idle_busy",  32'(busy),   32'd0);

      // Back-to-back with start held through the done cycle.
      a = 8'h80;
      b = 8'h7F;
      start = 1'b1;
      tick();
      lat = 0;
      while (!done && lat < 20) begin
         tick();
         lat++;
      end
      chk("b2b0.lat",  32'(lat),  32'd8);
      chk("b2b0.diff", 32'(diff), 32'h01);
      chk("b2b0.bout", 32'(bout), 32'd0);
      a = 8'h7F;
      b = 8'h80;
      tick();
      start = 1'b0;
      chk("b2b1.busy_now",  32'(busy), 32'd1);
      chk("b2b1.diff_hold", 32'(diff), 32'h01);
      lat = 1;
      while (!done && lat < 20) begin
         tick();
         lat++;
      end
      chk("b2b1.spacing", 32'(lat),  32'd9);
      chk("b2b1.diff",    32'(diff), 32'hFF);
      chk("b2b1.bout",    32'(bout), 32'd1);
      tick();

      // Reset in the middle of an operation.
      a = 8'hAA;
      b = 8'h55;
      start = 1'b1;
      tick();
      start = 1'b0;
      repeat (4) tick();
      #2;
      rst_n = 1'b0;
      #1;
      chk("abort.busy", 32'(busy), 32'd0);
      chk("abort.done", 32'(done), 32'd0);
      chk("abort.diff", 32'(diff), 32'd0);
      chk("abort.bout", 32'(bout), 32'd0);
      tick();
      rst_n = 1'b1;
      pulses = 0;
      repeat (12) begin
         tick();
         if (done || busy) pulses++;
      end
      chk("abort.no_done", 32'(pulses), 32'd0);
      do_op("fresh", 8'hAA, 8'h55, 8'h55, 1'b0);

      // Corner pairs, then random pairs chained back-to-back.
      do_op("c0000", 8'h00, 8'h00, 8'h00, 1'b0);
      do_op("cffff", 8'hFF, 8'hFF, 8'h00, 1'b0);
      do_op("c00ff", 8'h00, 8'hFF, 8'h01, 1'b1);
      do_op("cff00", 8'hFF, 8'h00, 8'hFF, 1'b0);
      for (int i = 0; i < 2000; i++) begin
         ra = W'($urandom_range(0, 255));
         rb = W'($urandom_range(0, 255));
         ref9 = {1'b0, ra} - {1'b0, rb};
         do_op("rnd", ra, rb, ref9[W-1:0], ref9[W]);
      end

      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule : tb_serial_subtractor
